y86_decode_wb_stage: RTL and testbench
======================================

// Module: y86_decode_wb_stage
// PURPOSE
//  Y86-64 pipeline decode/write-back slice. Holds the F->D pipeline register,
//  the 15-entry register file (decode reads, write-back writes) and the PC
//  update register. Sits between fetch and the D->E register; drives the next PC.
// PARAMETERS
//  AOK_CODE  3'b001  status code for a normal instruction (bubble/reset status)
//  NREGS     15      architectural registers 0..14; ID 4'hF = RNONE
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  F_status   in   3   fetch status (001 AOK, 010 INS, 100 HLT)
//  F_icode    in   4   fetched icode
//  F_ifun     in   4   fetched ifun
//  F_rA/F_rB  in   4   fetched register IDs
//  F_valC     in   64  fetched constant
//  F_valP     in   64  fetched fall-through PC
//  D_stall    in   1   hold D register
//  D_bubble   in   1   load nop bubble into D register
//  d_status/d_icode/d_ifun/d_rA/d_rB  out 3/4/4/4/4  registered D fields
//  d_valC/d_valP  out  64  registered D constants
//  d_valA/d_valB  out  64  combinational operand reads
//  W_icode    in   4   write-back icode
//  W_rA/W_rB  in   4   write-back register IDs
//  W_Cnd      in   1   write-back condition flag
//  W_valE/W_valM  in   64  ALU result / memory read value
//  W_valC     in   64  write-back constant (branch/call target)
//  pred_PC    in   64  predicted next PC from fetch
//  PC         out  64  registered next PC
//  Ro0..Ro14  out  64 each  live register-file contents
// BEHAVIOUR
//  - icodes: 0 halt,1 nop,2 rrmov/cmov,3 irmov,4 rmmov,5 mrmov,6 OPq,7 jXX,
//    8 call,9 ret,A push,B pop. RSP = reg 4.
//  - Reset (sync): d_status=AOK_CODE, d_icode=1, d_ifun=0, d_rA=d_rB=F,
//    d_valC=d_valP=0; all 15 registers=0; PC=0.
//  - D register: D_stall holds; else D_bubble loads reset values; else
//    captures F_*. Stall+bubble together: stall wins. Latency 1 cycle.
//  - srcA: rA for 2,4,6,A; RSP for 9,B; else RNONE.
//    srcB: rB for 4,5,6; RSP for 8,9,A,B; else RNONE.
//  - d_valA = d_valP when d_icode is 7 or 8; else RF[srcA]; RNONE reads 0.
//    d_valB = RF[srcB]; RNONE reads 0.
//  - dstE: rB for 3,6, and for 2 only when W_Cnd=1; RSP for 8,9,A,B; else none.
//    dstM: rA for 5,B; else none.
//  - On posedge (not reset): RF[dstE]<=W_valE, RF[dstM]<=W_valM; same target:
//    W_valM wins (popq %rsp). RNONE destinations never written.
//  - PC register on posedge: W_icode=8 -> W_valC; 7 with W_Cnd=1 -> W_valC;
//    9 -> W_valM; otherwise pred_PC. No other PC sources.
//  - Reset has priority over stall/bubble and over any write-back that cycle.
// CONFIGURATION
//  RF_BYPASS_EN defined: d_valA/d_valB combinationally return the incoming
//  W_valM/W_valE when srcA/srcB equals dstM/dstE this cycle (dstM priority).
//  Not defined: reads return pre-edge register contents only.
// TESTING
//  - rst=1 one edge -> d_icode=1, d_rA=F, PC=0, Ro0..Ro14=0.
//  - W_icode=3,W_rB=2,W_valE=0x55 -> Ro2=0x55 next edge; D fetch rrmov rA=2 -> d_valA=0x55.
//  - W_icode=B,W_rA=4,W_valE=8,W_valM=0x99 -> Ro4=0x99 (valM wins).
//  - W_icode=7,W_Cnd=1,W_valC=0x40 -> PC=0x40; W_Cnd=0,pred_PC=0x0A -> PC=0x0A.
//  - D_stall=1,D_bubble=1 with new F_icode=6 -> D fields unchanged; D_bubble only -> d_icode=1.
//  - RF_BYPASS_EN: W_icode=3,W_rB=3,W_valE=7 while d reads rA=3 -> d_valA=7 same cycle.

Source files
------------

// File: rtl/y86_decode_wb_stage_if.sv
// rtl/y86_decode_wb_stage_if.sv - fetch/decode/write-back signal bundle for the decode/write-back slice
interface y86_decode_wb_stage_if;
  // Fetch side into the D register
  logic [2:0]  F_status;
  logic [3:0]  F_icode;
  logic [3:0]  F_ifun;
  logic [3:0]  F_rA;
  logic [3:0]  F_rB;
  logic [63:0] F_valC;
  logic [63:0] F_valP;
  logic        D_stall;
  logic        D_bubble;

  // Registered D fields and operand reads
  logic [2:0]  d_status;
  logic [3:0]  d_icode;
  logic [3:0]  d_ifun;
  logic [3:0]  d_rA;
  logic [3:0]  d_rB;
  logic [63:0] d_valC;
  logic [63:0] d_valP;
  logic [63:0] d_valA;
  logic [63:0] d_valB;

  // Write-back side
  logic [3:0]  W_icode;
  logic [3:0]  W_rA;
  logic [3:0]  W_rB;
  logic        W_Cnd;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [63:0] W_valC;

  // PC update
  logic [63:0] pred_PC;
  logic [63:0] PC;

  // Live register file contents
  logic [63:0] Ro0, Ro1, Ro2, Ro3, Ro4, Ro5, Ro6, Ro7;
  logic [63:0] Ro8, Ro9, Ro10, Ro11, Ro12, Ro13, Ro14;

  modport master (
    output F_status, F_icode, F_ifun, F_rA, F_rB, F_valC, F_valP,
    output D_stall, D_bubble,
    output W_icode, W_rA, W_rB, W_Cnd, W_valE, W_valM, W_valC, pred_PC,
    input  d_status, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
    input  PC,
    input  Ro0, Ro1, Ro2, Ro3, Ro4, Ro5, Ro6, Ro7,
    input  Ro8, Ro9, Ro10, Ro11, Ro12, Ro13, Ro14
  );

  modport slave (
    input  F_status, F_icode, F_ifun, F_rA, F_rB, F_valC, F_valP,
    input  D_stall, D_bubble,
    input  W_icode, W_rA, W_rB, W_Cnd, W_valE, W_valM, W_valC, pred_PC,
    output d_status, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
    output PC,
    output Ro0, Ro1, Ro2, Ro3, Ro4, Ro5, Ro6, Ro7,
    output Ro8, Ro9, Ro10, Ro11, Ro12, Ro13, Ro14
  );
endinterface

// File: rtl/y86_decode_wb_stage.sv
// rtl/y86_decode_wb_stage.sv - Y86-64 decode/write-back slice (D register, register file, PC); optional RF_BYPASS_EN
module y86_decode_wb_stage #(
  parameter logic [2:0] AOK_CODE = 3'b001,
  parameter int         NREGS    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  y86_decode_wb_stage_if.slave   bus
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'h4;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [2:0]  r_status;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_rA;
  logic [3:0]  r_rB;
  logic [63:0] r_valC;
  logic [63:0] r_valP;
  logic [63:0] r_pc;
  logic [63:0] r_rf [0:NREGS-1];

  logic [3:0]  w_srcA;
  logic [3:0]  w_srcB;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_rd_a;
  logic [63:0] w_rd_b;

  // D pipeline register: stall holds, bubble injects a nop, otherwise capture fetch
  always_ff @(posedge clk) begin
    if (rst || (!bus.D_stall && bus.D_bubble)) begin
      r_status <= AOK_CODE;
      r_icode  <= I_NOP;
      r_ifun   <= 4'h0;
      r_rA     <= RNONE;
      r_rB     <= RNONE;
      r_valC   <= 64'd0;
      r_valP   <= 64'd0;
    end else if (!bus.D_stall) begin
      r_status <= bus.F_status;
      r_icode  <= bus.F_icode;
      r_ifun   <= bus.F_ifun;
      r_rA     <= bus.F_rA;
      r_rB     <= bus.F_rB;
      r_valC   <= bus.F_valC;
      r_valP   <= bus.F_valP;
    end
  end

  // Decode-side source register selection from the instruction held in D
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    case (r_icode)
      I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: w_srcA = r_rA;
      I_RET, I_POP:                    w_srcA = RSP;
      default:                         w_srcA = RNONE;
    endcase
    case (r_icode)
      I_RMMOV, I_MRMOV, I_OPQ:         w_srcB = r_rB;
      I_CALL, I_RET, I_PUSH, I_POP:    w_srcB = RSP;
      default:                         w_srcB = RNONE;
    endcase
  end

  // Write-back destination selection; a cmov that did not fire writes nothing
  always_comb begin
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (bus.W_icode)
      I_IRMOV, I_OPQ:                  w_dstE = bus.W_rB;
      I_RRMOV:                         w_dstE = bus.W_Cnd ? bus.W_rB : RNONE;
      I_CALL, I_RET, I_PUSH, I_POP:    w_dstE = RSP;
      default:                         w_dstE = RNONE;
    endcase
    case (bus.W_icode)
      I_MRMOV, I_POP:                  w_dstM = bus.W_rA;
      default:                         w_dstM = RNONE;
    endcase
  end

  // Register file reads; RNONE reads as zero, optional forwarding of this cycle's write-back
  always_comb begin
    w_rd_a = (w_srcA == RNONE) ? 64'd0 : r_rf[w_srcA];
    w_rd_b = (w_srcB == RNONE) ? 64'd0 : r_rf[w_srcB];
`ifdef RF_BYPASS_EN
    if (w_srcA != RNONE && w_srcA == w_dstM) begin
      w_rd_a = bus.W_valM;
    end else if (w_srcA != RNONE && w_srcA == w_dstE) begin
      w_rd_a = bus.W_valE;
    end
    if (w_srcB != RNONE && w_srcB == w_dstM) begin
      w_rd_b = bus.W_valM;
    end else if (w_srcB != RNONE && w_srcB == w_dstE) begin
      w_rd_b = bus.W_valE;
    end
`endif
  end

  // Register file writes; the memory result beats the ALU result on a shared target (popq %rsp)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        r_rf[i] <= 64'd0;
      end else if (w_dstM == i[3:0]) begin
        r_rf[i] <= bus.W_valM;
      end else if (w_dstE == i[3:0]) begin
        r_rf[i] <= bus.W_valE;
      end
    end
  end

  // Next-PC register: call and taken jumps go to valC, ret to the popped address, else prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= 64'd0;
    end else if (bus.W_icode == I_CALL) begin
      r_pc <= bus.W_valC;
    end else if (bus.W_icode == I_JXX && bus.W_Cnd) begin
      r_pc <= bus.W_valC;
    end else if (bus.W_icode == I_RET) begin
      r_pc <= bus.W_valM;
    end else begin
      r_pc <= bus.pred_PC;
    end
  end

  assign bus.d_status = r_status;
  assign bus.d_icode  = r_icode;
  assign bus.d_ifun   = r_ifun;
  assign bus.d_rA     = r_rA;
  assign bus.d_rB     = r_rB;
  assign bus.d_valC   = r_valC;
  assign bus.d_valP   = r_valP;
  assign bus.d_valA   = (r_icode == I_JXX || r_icode == I_CALL) ? r_valP : w_rd_a;
  assign bus.d_valB   = w_rd_b;
  assign bus.PC       = r_pc;

  assign bus.Ro0  = r_rf[0];
  assign bus.Ro1  = r_rf[1];
  assign bus.Ro2  = r_rf[2];
  assign bus.Ro3  = r_rf[3];
  assign bus.Ro4  = r_rf[4];
  assign bus.Ro5  = r_rf[5];
  assign bus.Ro6  = r_rf[6];
  assign bus.Ro7  = r_rf[7];
  assign bus.Ro8  = r_rf[8];
  assign bus.Ro9  = r_rf[9];
  assign bus.Ro10 = r_rf[10];
  assign bus.Ro11 = r_rf[11];
  assign bus.Ro12 = r_rf[12];
  assign bus.Ro13 = r_rf[13];
  assign bus.Ro14 = r_rf[14];

endmodule

// File: tb/tb_y86_decode_wb_stage.sv
// tb/tb_y86_decode_wb_stage.sv - scoreboard bench for the Y86-64 decode/write-back slice
module tb_y86_decode_wb_stage;

  localparam int S_DSTAT = 1;
  localparam int S_DICODE = 2;
  localparam int S_DIFUN = 3;
  localparam int S_DRA = 4;
  localparam int S_DRB = 5;
  localparam int S_DVALC = 6;
  localparam int S_DVALP = 7;
  localparam int S_DVALA = 8;
  localparam int S_DVALB = 9;
  localparam int S_PC = 10;
  localparam int S_RO = 100;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_decode_wb_stage_if bus ();

  y86_decode_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  function automatic logic [63:0] observe(int sel);
    logic [63:0] v;
    v = '0;
    case (sel)
      S_DSTAT:  v = {61'd0, bus.d_status};
      S_DICODE: v = {60'd0, bus.d_icode};
      S_DIFUN:  v = {60'd0, bus.d_ifun};
      S_DRA:    v = {60'd0, bus.d_rA};
      S_DRB:    v = {60'd0, bus.d_rB};
      S_DVALC:  v = bus.d_valC;
      S_DVALP:  v = bus.d_valP;
      S_DVALA:  v = bus.d_valA;
      S_DVALB:  v = bus.d_valB;
      S_PC:     v = bus.PC;
      S_RO + 0:  v = bus.Ro0;
      S_RO + 1:  v = bus.Ro1;
      S_RO + 2:  v = bus.Ro2;
      S_RO + 3:  v = bus.Ro3;
      S_RO + 4:  v = bus.Ro4;
      S_RO + 5:  v = bus.Ro5;
      S_RO + 6:  v = bus.Ro6;
      S_RO + 7:  v = bus.Ro7;
      S_RO + 8:  v = bus.Ro8;
      S_RO + 9:  v = bus.Ro9;
      S_RO + 10: v = bus.Ro10;
      S_RO + 11: v = bus.Ro11;
      S_RO + 12: v = bus.Ro12;
      S_RO + 13: v = bus.Ro13;
      S_RO + 14: v = bus.Ro14;
      default:   v = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
    return v;
  endfunction

  // Monitor: drains the scoreboard whenever the stimulus signals outputs are settled
  initial begin : monitor
    exp_t        e;
    logic [63:0] got;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = observe(e.sel);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int sel, input logic [63:0] v, input string n);
    exp_t e;
    e.sel  = sel;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_now();
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    bus.F_status = st;
    bus.F_icode  = ic;
    bus.F_ifun   = fn;
    bus.F_rA     = ra;
    bus.F_rB     = rb;
    bus.F_valC   = vc;
    bus.F_valP   = vp;
  endtask

  task automatic set_w(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [63:0] vc, input logic [63:0] pp);
    bus.W_icode = ic;
    bus.W_rA    = ra;
    bus.W_rB    = rb;
    bus.W_Cnd   = cnd;
    bus.W_valE  = ve;
    bus.W_valM  = vm;
    bus.W_valC  = vc;
    bus.pred_PC = pp;
  endtask

  initial begin : stimulus
    rst = 1'b1;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    set_f(3'b001, 4'h6, 4'h0, 4'h1, 4'h2, 64'h11, 64'h22);
    set_w(4'h3, 4'hF, 4'h2, 1'b0, 64'h5, 64'h6, 64'h7, 64'h8);

    // Reset state
    tick();
    expect_val(S_DSTAT, 64'd1, "rst_d_status");
    expect_val(S_DICODE, 64'd1, "rst_d_icode");
    expect_val(S_DRA, 64'hF, "rst_d_rA");
    expect_val(S_DRB, 64'hF, "rst_d_rB");
    expect_val(S_DVALP, 64'd0, "rst_d_valP");
    expect_val(S_PC, 64'd0, "rst_PC");
    expect_val(S_RO + 0, 64'd0, "rst_Ro0");
    expect_val(S_RO + 2, 64'd0, "rst_Ro2");
    expect_val(S_RO + 14, 64'd0, "rst_Ro14");
    check_now();
    rst = 1'b0;

    // irmovq to %rdx; D captures rrmovq reading rA=2
    set_f(3'b001, 4'h2, 4'h0, 4'h2, 4'h3, 64'h0, 64'h20);
    set_w(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 64'h0, 64'h10);
    tick();
    expect_val(S_RO + 2, 64'h55, "irmov_Ro2");
    expect_val(S_PC, 64'h10, "irmov_PC_pred");
    expect_val(S_DICODE, 64'h2, "rrmov_d_icode");
    expect_val(S_DVALA, 64'h55, "rrmov_d_valA");
    expect_val(S_DVALB, 64'h0, "rrmov_d_valB_none");
    check_now();

    // popq %rsp: valM wins; D holds pushq rA=2
    set_f(3'b001, 4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h32);
    set_w(4'hB, 4'h4, 4'hF, 1'b0, 64'h8, 64'h99, 64'h0, 64'h30);
    tick();
    expect_val(S_RO + 4, 64'h99, "popq_rsp_Ro4");
    expect_val(S_PC, 64'h30, "popq_PC_pred");
    expect_val(S_DVALA, 64'h55, "push_d_valA");
    expect_val(S_DVALB, 64'h99, "push_d_valB_rsp");
    check_now();

    // Taken jump redirects PC; D jXX reads valP through valA
    set_f(3'b001, 4'h7, 4'h3, 4'hF, 4'hF, 64'h1234, 64'h77);
    set_w(4'h7, 4'hF, 4'hF, 1'b1, 64'h0, 64'h0, 64'h40, 64'h50);
    tick();
    expect_val(S_PC, 64'h40, "jxx_taken_PC");
    expect_val(S_DVALA, 64'h77, "jxx_d_valA_valP");
    expect_val(S_DVALC, 64'h1234, "jxx_d_valC");
    expect_val(S_DIFUN, 64'h3, "jxx_d_ifun");
    expect_val(S_RO + 2, 64'h55, "jxx_Ro2_kept");
    check_now();

    // Not-taken jump follows prediction; D mrmovq reads rB=2
    set_f(3'b001, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 64'h8A);
    set_w(4'h7, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h40, 64'h0A);
    tick();
    expect_val(S_PC, 64'h0A, "jxx_nottaken_PC");
    expect_val(S_DICODE, 64'h5, "mrmov_d_icode");
    expect_val(S_DVALA, 64'h0, "mrmov_d_valA_none");
    expect_val(S_DVALB, 64'h55, "mrmov_d_valB");
    check_now();

    // Stall and bubble together: stall wins; call writes RSP and redirects PC
    bus.D_stall  = 1'b1;
    bus.D_bubble = 1'b1;
    set_f(3'b001, 4'h6, 4'h0, 4'h3, 4'h4, 64'h0, 64'h99);
    set_w(4'h8, 4'hF, 4'hF, 1'b0, 64'h1000, 64'h0, 64'h200, 64'h11);
    tick();
    expect_val(S_DICODE, 64'h5, "stall_d_icode_held");
    expect_val(S_DRA, 64'h1, "stall_d_rA_held");
    expect_val(S_DVALP, 64'h8A, "stall_d_valP_held");
    expect_val(S_PC, 64'h200, "call_PC");
    expect_val(S_RO + 4, 64'h1000, "call_Ro4");
    check_now();

    // Bubble only: D becomes nop; ret takes PC from valM and writes RSP from valE
    bus.D_stall = 1'b0;
    set_w(4'h9, 4'hF, 4'hF, 1'b0, 64'h1008, 64'h300, 64'h0, 64'h12);
    tick();
    expect_val(S_DICODE, 64'h1, "bubble_d_icode");
    expect_val(S_DRA, 64'hF, "bubble_d_rA");
    expect_val(S_DRB, 64'hF, "bubble_d_rB");
    expect_val(S_DVALP, 64'h0, "bubble_d_valP");
    expect_val(S_DSTAT, 64'h1, "bubble_d_status");
    expect_val(S_PC, 64'h300, "ret_PC");
    expect_val(S_RO + 4, 64'h1008, "ret_Ro4");
    check_now();

    // Untaken cmov writes nothing; D captures a halt with HLT status
    bus.D_bubble = 1'b0;
    set_f(3'b100, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    set_w(4'h2, 4'hF, 4'h5, 1'b0, 64'hAA, 64'h0, 64'h0, 64'h13);
    tick();
    expect_val(S_RO + 5, 64'h0, "cmov_nottaken_Ro5");
    expect_val(S_PC, 64'h13, "cmov_PC_pred");
    expect_val(S_DSTAT, 64'h4, "halt_d_status");
    expect_val(S_DICODE, 64'h0, "halt_d_icode");
    check_now();

    // Taken cmov writes rB
    set_w(4'h2, 4'hF, 4'h6, 1'b1, 64'hBB, 64'h0, 64'h0, 64'h14);
    tick();
    expect_val(S_RO + 6, 64'hBB, "cmov_taken_Ro6");
    check_now();

    // RNONE destination is never written
    set_w(4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0, 64'h0, 64'h15);
    tick();
    expect_val(S_RO + 14, 64'h0, "rnone_Ro14");
    expect_val(S_RO + 0, 64'h0, "rnone_Ro0");
    expect_val(S_RO + 6, 64'hBB, "rnone_Ro6_kept");
    check_now();

    // mrmovq into the highest register
    set_w(4'h5, 4'hE, 4'h3, 1'b0, 64'h1, 64'hEE, 64'h0, 64'h16);
    tick();
    expect_val(S_RO + 14, 64'hEE, "mrmov_Ro14");
    expect_val(S_RO + 3, 64'h0, "mrmov_Ro3_untouched");
    expect_val(S_PC, 64'h16, "mrmov_PC_pred");
    check_now();

    // Reset beats stall and a concurrent write-back
    rst = 1'b1;
    bus.D_stall = 1'b1;
    set_f(3'b001, 4'h6, 4'h0, 4'h3, 4'h4, 64'h0, 64'h5);
    set_w(4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0, 64'h0, 64'h99);
    tick();
    expect_val(S_RO + 7, 64'h0, "rstprio_Ro7");
    expect_val(S_RO + 2, 64'h0, "rstprio_Ro2");
    expect_val(S_RO + 14, 64'h0, "rstprio_Ro14");
    expect_val(S_PC, 64'h0, "rstprio_PC");
    expect_val(S_DICODE, 64'h1, "rstprio_d_icode");
    expect_val(S_DRA, 64'hF, "rstprio_d_rA");
    check_now();
    rst = 1'b0;
    bus.D_stall = 1'b0;

    // Same-cycle read of a register being written back
    set_f(3'b001, 4'h2, 4'h0, 4'h3, 4'hF, 64'h0, 64'h0);
    set_w(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h20);
    tick();
    set_w(4'h3, 4'hF, 4'h3, 1'b0, 64'h7, 64'h0, 64'h0, 64'h21);
    #1;
`ifdef RF_BYPASS_EN
    expect_val(S_DVALA, 64'h7, "bypass_d_valA");
`else
    expect_val(S_DVALA, 64'h0, "nobypass_d_valA");
`endif
    check_now();
    tick();
    expect_val(S_RO + 3, 64'h7, "late_Ro3");
    expect_val(S_DVALA, 64'h7, "late_d_valA");
    check_now();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
